ncc_window_sequencer: RTL and testbench
=======================================

// Module: ncc_window_sequencer
// PURPOSE
//  Sequences the NCC line-accumulation datapath (sum I, sum I^2, sum T*I per template) over one window.
//  Accepts NUM_OF_LINES lines from the line source by valid/ready and clears the accumulators at window start.
//  After the datapath pipeline drains, captures the window sums into holding registers.
//  Presents the held sums to the downstream normaliser by valid/ready. Sits between line fetch and Top.
// PARAMETERS
//  PIXEL_SIZE     8  pixel width in bits
//  LINE_SIZE      8  pixels per line
//  NUM_OF_LINES   8  lines per window (>=1)
//  NUM_TEMPLATES  4  template count
//  PIPE_LAT       2  cycles from acc_en to the line's contribution appearing on acc_* (>=1)
//  ACC_W  derived: $clog2(NUM_OF_LINES)+$clog2(LINE_SIZE)+2*PIXEL_SIZE
// PORTS
//  CLK           in   1                  clock, rising edge
//  reset         in   1                  asynchronous, active-high
//  start         in   1                  begin a window; sampled only in IDLE
//  line_valid    in   1                  source presents a line on the I/T buses
//  line_ready    out  1                  sequencer will accept a line this cycle
//  acc_clear     out  1                  one-cycle synchronous clear to datapath accumulators
//  acc_en        out  1                  line_valid&line_ready: datapath consumes line
//  acc_sum_I     in   ACC_W              datapath sum I
//  acc_sum_I_sq  in   ACC_W              datapath sum I^2
//  acc_sum_TxI   in   NUM_TEMPLATES*ACC_W  template k at [k*ACC_W +: ACC_W]
//  res_valid     out  1                  held result available
//  res_ready     in   1                  consumer accepts result
//  res_sum_I     out  ACC_W              held sum I
//  res_sum_I_sq  out  ACC_W              held sum I^2
//  res_sum_TxI   out  NUM_TEMPLATES*ACC_W  held sum T*I, same packing as acc_sum_TxI
//  line_cnt      out  $clog2(NUM_OF_LINES+1)  lines accepted in current window
//  busy          out  1                  state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, including res_* and line_cnt; drain counter 0. Reset is async; mid-window reset abandons the window.
//  FSM: IDLE -> CLEAR -> LOAD -> DRAIN -> HOLD -> IDLE.
//  IDLE: line_ready=0. start=1 at an edge -> CLEAR.
//  CLEAR: exactly one cycle; acc_clear=1, line_cnt<=0 -> LOAD.
//  LOAD: line_ready=1; acc_en = line_valid (combinational).
//    Each accepting edge increments line_cnt.
//    The accepting edge with line_cnt==NUM_OF_LINES-1 sets line_cnt=NUM_OF_LINES, dcnt<=PIPE_LAT-1 -> DRAIN.
//  DRAIN: line_ready=0. dcnt!=0: dcnt--. dcnt==0: res_* <= acc_*, res_valid<=1 -> HOLD.
//    res_valid therefore rises PIPE_LAT edges after the last-line acceptance edge.
//  HOLD: res_valid=1; res_* stable regardless of acc_* changes.
//    res_ready=1 at an edge -> res_valid<=0 -> IDLE (or CLEAR, see CONFIGURATION).
//  Boundaries:
//    start outside IDLE is ignored, not queued.
//    line_valid outside LOAD: no acc_en.
//    start and res_ready are both ignored in CLEAR/DRAIN.
//    res_sum_* retain the last window's values after handshake until the next capture.
//  Widths: no arithmetic here; ACC_W guarantees no overflow in the datapath for a full window.
// CONFIGURATION
//  NCC_SEQ_AUTORESTART_EN defined: HOLD + res_ready -> CLEAR directly (next window without start); busy stays 1.
//  Undefined: HOLD + res_ready -> IDLE; the next window requires a start pulse.
// TESTING  (NUM_OF_LINES=4, PIPE_LAT=2, NUM_TEMPLATES=4)
//  1 reset=1 async mid-cycle -> all outputs 0 immediately; busy=0; line_ready=0.
//  2 start pulse, line_valid=1 held, acc_sum_I=1234 -> acc_clear 1 cycle, then 4 consecutive acc_en cycles.
//    res_valid rises 2 edges after the 4th acceptance; res_sum_I=1234.
//  3 line_valid pattern 1,0,1,0,1,0,1 in LOAD -> exactly 4 acc_en pulses; line_cnt steps 1..4; DRAIN follows the 4th.
//  4 HOLD with res_ready=0 for 10 cycles, acc_* randomised, start pulsed -> res_* unchanged.
//    res_valid=1 throughout; no acc_clear; then res_ready=1 -> res_valid=0 next cycle.
//  5 reset pulse in LOAD at line_cnt=2 -> IDLE, line_cnt=0.
//    A following start yields a full 4-line window with a fresh acc_clear.
//  6 AUTORESTART_EN: res_ready in HOLD -> acc_clear the next cycle without start.
//    Without the macro -> IDLE, busy=0.

Source files
------------

// File: rtl/ncc_window_sequencer_if.sv
// Bundle of the sequencer's control, line, datapath and result signals.
// slave  : the sequencer side.
// master : the environment side, which covers the line source, the datapath and the normaliser.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
// valid must not depend on ready.
interface ncc_window_sequencer_if #(
  parameter int PIXEL_SIZE    = 8,
  parameter int LINE_SIZE     = 8,
  parameter int NUM_OF_LINES  = 8,
  parameter int NUM_TEMPLATES = 4
);
  localparam int ACC_W  = $clog2(NUM_OF_LINES) + $clog2(LINE_SIZE) + 2 * PIXEL_SIZE;
  localparam int LCNT_W = $clog2(NUM_OF_LINES + 1);

  logic                             start;
  logic                             line_valid;
  logic                             line_ready;
  logic                             acc_clear;
  logic                             acc_en;
  logic [ACC_W-1:0]                 acc_sum_I;
  logic [ACC_W-1:0]                 acc_sum_I_sq;
  logic [NUM_TEMPLATES*ACC_W-1:0]   acc_sum_TxI;
  logic                             res_valid;
  logic                             res_ready;
  logic [ACC_W-1:0]                 res_sum_I;
  logic [ACC_W-1:0]                 res_sum_I_sq;
  logic [NUM_TEMPLATES*ACC_W-1:0]   res_sum_TxI;
  logic [LCNT_W-1:0]                line_cnt;
  logic                             busy;

  modport slave (
    input  start, line_valid, acc_sum_I, acc_sum_I_sq, acc_sum_TxI, res_ready,
    output line_ready, acc_clear, acc_en, res_valid, res_sum_I, res_sum_I_sq,
           res_sum_TxI, line_cnt, busy
  );

  modport master (
    output start, line_valid, acc_sum_I, acc_sum_I_sq, acc_sum_TxI, res_ready,
    input  line_ready, acc_clear, acc_en, res_valid, res_sum_I, res_sum_I_sq,
           res_sum_TxI, line_cnt, busy
  );
endinterface

// File: rtl/ncc_window_sequencer.sv
// ncc_window_sequencer
// Runs one NCC accumulation window.
// Sequence: clear the datapath, accept NUM_OF_LINES lines, wait PIPE_LAT cycles
// for the pipeline to drain, capture the sums, then hold them until the
// normaliser takes them.
// Optional feature macro: NCC_SEQ_AUTORESTART_EN.
//   When defined, a result handshake goes straight to the next window's clear.
//   When undefined, the sequencer returns to IDLE and waits for start.
// dbg_state_o exposes the FSM state.
// Encoding: 0 IDLE, 1 CLEAR, 2 LOAD, 3 DRAIN, 4 HOLD.
module ncc_window_sequencer #(
  parameter int PIXEL_SIZE    = 8,
  parameter int LINE_SIZE     = 8,
  parameter int NUM_OF_LINES  = 8,
  parameter int NUM_TEMPLATES = 4,
  parameter int PIPE_LAT      = 2
) (
  input  logic                   CLK,
  input  logic                   reset,
  ncc_window_sequencer_if.slave  bus,
  output logic [2:0]             dbg_state_o
);
  localparam int ACC_W  = $clog2(NUM_OF_LINES) + $clog2(LINE_SIZE) + 2 * PIXEL_SIZE;
  localparam int LCNT_W = $clog2(NUM_OF_LINES + 1);
  localparam int DCNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int TXI_W  = NUM_TEMPLATES * ACC_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  localparam logic [LCNT_W-1:0] LAST_LINE = LCNT_W'(NUM_OF_LINES - 1);
  localparam logic [LCNT_W-1:0] ALL_LINES = LCNT_W'(NUM_OF_LINES);
  localparam logic [DCNT_W-1:0] DRAIN_TOP = DCNT_W'(PIPE_LAT - 1);

  logic [2:0]        state_q, state_d;
  logic [LCNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              res_valid_q, res_valid_d;
  logic [ACC_W-1:0]  res_i_q, res_i_d;
  logic [ACC_W-1:0]  res_sq_q, res_sq_d;
  logic [TXI_W-1:0]  res_txi_q, res_txi_d;
  logic              accept;

  // A line is taken only while loading; the source's valid is ignored elsewhere.
  assign accept = (state_q == S_LOAD) && bus.line_valid;

  // The next state is computed here, together with the counters and the result capture.
  always_comb begin
    state_d     = state_q;
    line_cnt_d  = line_cnt_q;
    dcnt_d      = dcnt_q;
    res_valid_d = res_valid_q;
    res_i_d     = res_i_q;
    res_sq_d    = res_sq_q;
    res_txi_d   = res_txi_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        line_cnt_d = '0;
        state_d    = S_LOAD;
      end
      S_LOAD: begin
        if (accept) begin
          if (line_cnt_q == LAST_LINE) begin
            line_cnt_d = ALL_LINES;
            dcnt_d     = DRAIN_TOP;
            state_d    = S_DRAIN;
          end else begin
            line_cnt_d = line_cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (dcnt_q != '0) begin
          dcnt_d = dcnt_q - 1'b1;
        end else begin
          // The last line's contribution is now visible on acc_*.
          res_i_d     = bus.acc_sum_I;
          res_sq_d    = bus.acc_sum_I_sq;
          res_txi_d   = bus.acc_sum_TxI;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
`ifdef NCC_SEQ_AUTORESTART_EN
          state_d     = S_CLEAR;
`else
          state_d     = S_IDLE;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers. Reset abandons any window in progress and clears the held results.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      line_cnt_q  <= '0;
      dcnt_q      <= '0;
      res_valid_q <= 1'b0;
      res_i_q     <= '0;
      res_sq_q    <= '0;
      res_txi_q   <= '0;
    end else begin
      state_q     <= state_d;
      line_cnt_q  <= line_cnt_d;
      dcnt_q      <= dcnt_d;
      res_valid_q <= res_valid_d;
      res_i_q     <= res_i_d;
      res_sq_q    <= res_sq_d;
      res_txi_q   <= res_txi_d;
    end
  end

  // Outputs are decoded from the registered state, so they all read 0 while in reset.
  always_comb begin
    bus.line_ready   = (state_q == S_LOAD);
    bus.acc_en       = accept;
    bus.acc_clear    = (state_q == S_CLEAR);
    bus.busy         = (state_q != S_IDLE);
    bus.res_valid    = res_valid_q;
    bus.res_sum_I    = res_i_q;
    bus.res_sum_I_sq = res_sq_q;
    bus.res_sum_TxI  = res_txi_q;
    bus.line_cnt     = line_cnt_q;
    dbg_state_o      = state_q;
  end
endmodule

// File: tb/tb_ncc_window_sequencer.sv
// Bench for ncc_window_sequencer with 4 lines per window, PIPE_LAT=2 and 4 templates.
// A small behavioural datapath sits behind the acc_* buses.
// It clears on acc_clear and adds each accepted line one cycle later.
// The driver sums every accepted line on its own and queues the window totals.
// The monitor pops the queue when res_valid rises.
module tb_ncc_window_sequencer;
  localparam int PIXEL_SIZE    = 8;
  localparam int LINE_SIZE     = 8;
  localparam int NUM_OF_LINES  = 4;
  localparam int NUM_TEMPLATES = 4;
  localparam int PIPE_LAT      = 2;
  localparam int ACC_W         = $clog2(NUM_OF_LINES) + $clog2(LINE_SIZE) + 2 * PIXEL_SIZE;
  localparam int RES_W         = (2 + NUM_TEMPLATES) * ACC_W;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;

  ncc_window_sequencer_if #(
    .PIXEL_SIZE(PIXEL_SIZE), .LINE_SIZE(LINE_SIZE),
    .NUM_OF_LINES(NUM_OF_LINES), .NUM_TEMPLATES(NUM_TEMPLATES)
  ) bus ();

  ncc_window_sequencer #(
    .PIXEL_SIZE(PIXEL_SIZE), .LINE_SIZE(LINE_SIZE), .NUM_OF_LINES(NUM_OF_LINES),
    .NUM_TEMPLATES(NUM_TEMPLATES), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .CLK(clk), .reset(rst), .bus(bus), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural datapath ----------------
  logic [ACC_W-1:0] ln_i, ln_sq;
  logic [ACC_W-1:0] ln_txi [NUM_TEMPLATES];
  logic             pv = 1'b0;
  logic [ACC_W-1:0] p_i = '0, p_sq = '0;
  logic [ACC_W-1:0] p_txi [NUM_TEMPLATES];
  logic [ACC_W-1:0] m_i = '0, m_sq = '0;
  logic [ACC_W-1:0] m_txi [NUM_TEMPLATES];
  logic             scramble = 1'b0;
  logic [ACC_W-1:0] r_i, r_sq;
  logic [NUM_TEMPLATES*ACC_W-1:0] r_txi;

  always @(posedge clk) begin
    pv   <= bus.acc_en;
    p_i  <= ln_i;
    p_sq <= ln_sq;
    for (int k = 0; k < NUM_TEMPLATES; k++) p_txi[k] <= ln_txi[k];
    if (bus.acc_clear) begin
      m_i  <= '0;
      m_sq <= '0;
      for (int k = 0; k < NUM_TEMPLATES; k++) m_txi[k] <= '0;
    end else if (pv) begin
      m_i  <= m_i + p_i;
      m_sq <= m_sq + p_sq;
      for (int k = 0; k < NUM_TEMPLATES; k++) m_txi[k] <= m_txi[k] + p_txi[k];
    end
  end

  always_comb begin
    bus.acc_sum_I    = scramble ? r_i : m_i;
    bus.acc_sum_I_sq = scramble ? r_sq : m_sq;
    bus.acc_sum_TxI  = r_txi;
    if (!scramble)
      for (int k = 0; k < NUM_TEMPLATES; k++) bus.acc_sum_TxI[k*ACC_W +: ACC_W] = m_txi[k];
  end

  // ---------------- scoreboard / monitor ----------------
  logic [RES_W-1:0] exp_q[$];
  logic [RES_W-1:0] last_exp = '0;
  logic             rv_prev = 1'b0;
  int               last_acc_cyc = 0;

  function automatic logic [RES_W-1:0] dut_res();
    return {bus.res_sum_TxI, bus.res_sum_I_sq, bus.res_sum_I};
  endfunction

  // The result is compared on the cycle res_valid rises, and its latency is measured from the last accepting edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.res_valid && !rv_prev) begin
        if (exp_q.size() == 0) begin
          chk("res_unexpected", 128'(1), 128'(0));
        end else begin
          chk("res_sums", 128'(dut_res()), 128'(exp_q.pop_front()));
        end
        chk("res_latency", 128'(cyc - last_acc_cyc - 1), 128'(PIPE_LAT));
      end
      if (bus.acc_en) last_acc_cyc = cyc;
    end
    rv_prev = bus.res_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic reset_check(input string tag);
    bus.line_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk({tag, "_line_ready"}, 128'(bus.line_ready), 128'(0));
    chk({tag, "_acc_en"},     128'(bus.acc_en),     128'(0));
    chk({tag, "_acc_clear"},  128'(bus.acc_clear),  128'(0));
    chk({tag, "_res_valid"},  128'(bus.res_valid),  128'(0));
    chk({tag, "_busy"},       128'(bus.busy),       128'(0));
    chk({tag, "_line_cnt"},   128'(bus.line_cnt),   128'(0));
    chk({tag, "_res_sums"},   128'(dut_res()),      128'(0));
    chk({tag, "_state"},      128'(dbg_state),      128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    bus.line_valid = 1'b0;
  endtask

  task automatic set_line(input bit fixed, input int idx);
    ln_i  = fixed ? ((idx == 3) ? ACC_W'(334) : ACC_W'(300)) : ACC_W'($urandom_range(0, 2040));
    ln_sq = ACC_W'($urandom_range(0, 500000));
    for (int k = 0; k < NUM_TEMPLATES; k++) ln_txi[k] = ACC_W'($urandom_range(0, 500000));
  endtask

  // Pulse start, then check the single clear cycle. Returns at posedge+1 with the DUT in LOAD.
  task automatic begin_window();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("clear_acc_clear", 128'(bus.acc_clear), 128'(1));
    chk("clear_busy",      128'(bus.busy),      128'(1));
    chk("clear_ready",     128'(bus.line_ready), 128'(0));
    bus.line_valid = 1'b1;
    @(negedge clk);
    chk("acc_en_in_clear", 128'(bus.acc_en), 128'(0));
    @(posedge clk); #1;
    chk("load_acc_clear",  128'(bus.acc_clear),  128'(0));
    chk("load_ready",      128'(bus.line_ready), 128'(1));
    chk("load_cnt0",       128'(bus.line_cnt),   128'(0));
  endtask

  task automatic feed_lines(input int n_lines, input bit alternate, input bit fixed,
                            output logic [RES_W-1:0] e);
    logic [ACC_W-1:0] e_i, e_sq;
    logic [ACC_W-1:0] e_txi [NUM_TEMPLATES];
    int got, i;
    bit acc;
    e_i = '0; e_sq = '0; got = 0; i = 0;
    for (int k = 0; k < NUM_TEMPLATES; k++) e_txi[k] = '0;
    while (got < n_lines && i < 40) begin
      bus.line_valid = alternate ? (i % 2 == 0) : 1'b1;
      set_line(fixed, got);
      @(negedge clk);
      acc = bus.acc_en;
      if (acc) begin
        got++;
        e_i  = e_i + ln_i;
        e_sq = e_sq + ln_sq;
        for (int k = 0; k < NUM_TEMPLATES; k++) e_txi[k] = e_txi[k] + ln_txi[k];
      end
      @(posedge clk); #1;
      if (acc) chk("line_cnt", 128'(bus.line_cnt), 128'(got));
      i++;
    end
    if (got < n_lines) chk("feed_timeout", 128'(got), 128'(n_lines));
    bus.line_valid = 1'b0;
    e = '0;
    e[ACC_W-1:0]         = e_i;
    e[2*ACC_W-1:ACC_W]   = e_sq;
    for (int k = 0; k < NUM_TEMPLATES; k++) e[(2+k)*ACC_W +: ACC_W] = e_txi[k];
  endtask

  task automatic run_window(input bit alternate, input bit fixed);
    logic [RES_W-1:0] e;
    begin_window();
    feed_lines(NUM_OF_LINES, alternate, fixed, e);
    exp_q.push_back(e);
    last_exp = e;
    chk("drain_ready", 128'(bus.line_ready), 128'(0));
    bus.line_valid = 1'b1;
    @(negedge clk);
    chk("acc_en_in_drain", 128'(bus.acc_en), 128'(0));
    @(posedge clk); #1;
    bus.line_valid = 1'b0;
  endtask

  task automatic wait_result();
    int n = 0;
    while (!bus.res_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.res_valid) chk("res_timeout", 128'(0), 128'(1));
  endtask

  task automatic handshake();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk("hs_res_valid", 128'(bus.res_valid), 128'(0));
    chk("hs_retained",  128'(dut_res()),     128'(last_exp));
`ifdef NCC_SEQ_AUTORESTART_EN
    chk("auto_acc_clear", 128'(bus.acc_clear), 128'(1));
    chk("auto_busy",      128'(bus.busy),      128'(1));
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
`else
    chk("idle_busy",      128'(bus.busy),      128'(0));
    chk("idle_acc_clear", 128'(bus.acc_clear), 128'(0));
    @(posedge clk); #1;
    chk("idle_stays",     128'(bus.busy),      128'(0));
`endif
  endtask

  task automatic hold_test();
    for (int i = 0; i < 10; i++) begin
      scramble  = 1'b1;
      r_i       = ACC_W'($urandom);
      r_sq      = ACC_W'($urandom);
      r_txi     = {$urandom, $urandom, $urandom};
      bus.start = (i == 3);
      @(negedge clk);
      chk("hold_res_valid", 128'(bus.res_valid), 128'(1));
      chk("hold_acc_clear", 128'(bus.acc_clear), 128'(0));
      chk("hold_res_sums",  128'(dut_res()),     128'(last_exp));
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    scramble  = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [RES_W-1:0] dummy;
    rst = 1'b1;
    bus.start = 1'b0; bus.line_valid = 1'b0; bus.res_ready = 1'b0;
    r_i = '0; r_sq = '0; r_txi = '0;
    for (int k = 0; k < NUM_TEMPLATES; k++) begin
      m_txi[k] = '0; p_txi[k] = '0; ln_txi[k] = '0;
    end
    ln_i = '0; ln_sq = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    reset_check("rst_init");

    run_window(1'b0, 1'b1);
    wait_result();
    chk("res_sum_I_1234", 128'(bus.res_sum_I), 128'(1234));
    handshake();

    run_window(1'b1, 1'b0);
    wait_result();
    handshake();

    run_window(1'b0, 1'b0);
    wait_result();
    hold_test();
    handshake();

    begin_window();
    feed_lines(2, 1'b0, 1'b0, dummy);
    chk("abort_cnt2", 128'(bus.line_cnt), 128'(2));
    reset_check("rst_load");
    run_window(1'b0, 1'b0);
    wait_result();
    handshake();

    repeat (2) @(posedge clk);
    chk("exp_q_empty", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
